// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes and the mem2axi FSM state encoding.
package axi_lite_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;
endpackage

// File: rtl/mem2axi_if.sv
// Request/response port plus AXI4-Lite channels of the mem2axi initiator.
interface mem2axi_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_w_req_valid;
  logic                  o_w_req_ready;
  logic                  i_w_req_we;
  logic [ADDR_WIDTH-1:0] i_w_req_addr;
  logic [DATA_WIDTH-1:0] i_w_req_wdata;
  logic                  o_w_rsp_valid;
  logic                  i_w_rsp_ready;
  logic                  o_w_rsp_we;
  logic [1:0]            o_w_rsp_resp;
  logic [DATA_WIDTH-1:0] o_w_rsp_rdata;
  logic                  o_w_awvalid;
  logic                  i_w_awready;
  logic [ADDR_WIDTH-1:0] o_w_awaddr;
  logic                  o_w_wvalid;
  logic                  i_w_wready;
  logic [DATA_WIDTH-1:0] o_w_wdata;
  logic                  i_w_bvalid;
  logic                  o_w_bready;
  logic [1:0]            i_w_bresp;
  logic                  o_w_arvalid;
  logic                  i_w_arready;
  logic [ADDR_WIDTH-1:0] o_w_araddr;
  logic                  i_w_rvalid;
  logic                  o_w_rready;
  logic [1:0]            i_w_rresp;
  logic [DATA_WIDTH-1:0] i_w_rdata;

  modport master (
    input  i_w_req_valid, i_w_req_we, i_w_req_addr, i_w_req_wdata, i_w_rsp_ready,
    input  i_w_awready, i_w_wready, i_w_bvalid, i_w_bresp,
    input  i_w_arready, i_w_rvalid, i_w_rresp, i_w_rdata,
    output o_w_req_ready, o_w_rsp_valid, o_w_rsp_we, o_w_rsp_resp, o_w_rsp_rdata,
    output o_w_awvalid, o_w_awaddr, o_w_wvalid, o_w_wdata, o_w_bready,
    output o_w_arvalid, o_w_araddr, o_w_rready
  );

  modport slave (
    output i_w_req_valid, i_w_req_we, i_w_req_addr, i_w_req_wdata, i_w_rsp_ready,
    output i_w_awready, i_w_wready, i_w_bvalid, i_w_bresp,
    output i_w_arready, i_w_rvalid, i_w_rresp, i_w_rdata,
    input  o_w_req_ready, o_w_rsp_valid, o_w_rsp_we, o_w_rsp_resp, o_w_rsp_rdata,
    input  o_w_awvalid, o_w_awaddr, o_w_wvalid, o_w_wdata, o_w_bready,
    input  o_w_arvalid, o_w_araddr, o_w_rready
  );
endinterface

// File: rtl/mem2axi.sv
// Single-outstanding AXI4-Lite initiator: turns one memory request into an
// AW/W/B or AR/R transaction and returns the result on a response port.
module mem2axi
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic       i_w_aclk,
  input  logic       i_w_areset,
  mem2axi_if.master  bus
);
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_width_check
    $error("mem2axi: DATA_WIDTH must be 32 or 64");
  end

  state_t                r_state, w_state_next;
  logic                  r_awvalid, r_wvalid, r_aw_done, r_w_done, r_bready;
  logic                  r_arvalid, r_rready;
  logic                  r_rsp_valid, r_rsp_we;
  logic [1:0]            r_rsp_resp;
  logic [DATA_WIDTH-1:0] r_rsp_rdata, r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic                  w_awvalid_next, w_wvalid_next, w_aw_done_next, w_w_done_next;
  logic                  w_bready_next, w_arvalid_next, w_rready_next;
  logic                  w_rsp_valid_next, w_rsp_we_next;
  logic [1:0]            w_rsp_resp_next;
  logic [DATA_WIDTH-1:0] w_rsp_rdata_next, w_wdata_next;
  logic [ADDR_WIDTH-1:0] w_addr_next;

  logic w_req_hs, w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_rsp_hs, w_wr_done;

  assign w_req_hs  = bus.i_w_req_valid && (r_state == IDLE);
  assign w_aw_hs   = r_awvalid && bus.i_w_awready;
  assign w_w_hs    = r_wvalid && bus.i_w_wready;
  assign w_b_hs    = r_bready && bus.i_w_bvalid;
  assign w_ar_hs   = r_arvalid && bus.i_w_arready;
  assign w_r_hs    = r_rready && bus.i_w_rvalid;
  assign w_rsp_hs  = r_rsp_valid && bus.i_w_rsp_ready;
  // AW and W may finish in either order or together; B waits for both.
  assign w_wr_done = (r_aw_done || w_aw_hs) && (r_w_done || w_w_hs);

  always_ff @(posedge i_w_aclk or posedge i_w_areset) begin
    if (i_w_areset) begin
      r_state     <= IDLE;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_we    <= 1'b0;
      r_rsp_resp  <= RESP_OKAY;
      r_rsp_rdata <= '0;
      r_wdata     <= '0;
      r_addr      <= '0;
    end else begin
      r_state     <= w_state_next;
      r_awvalid   <= w_awvalid_next;
      r_wvalid    <= w_wvalid_next;
      r_aw_done   <= w_aw_done_next;
      r_w_done    <= w_w_done_next;
      r_bready    <= w_bready_next;
      r_arvalid   <= w_arvalid_next;
      r_rready    <= w_rready_next;
      r_rsp_valid <= w_rsp_valid_next;
      r_rsp_we    <= w_rsp_we_next;
      r_rsp_resp  <= w_rsp_resp_next;
      r_rsp_rdata <= w_rsp_rdata_next;
      r_wdata     <= w_wdata_next;
      r_addr      <= w_addr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_req_hs) w_state_next = bus.i_w_req_we ? WR : RD_ADDR;
      WR:      if (w_wr_done) w_state_next = WR_RESP;
      WR_RESP: if (w_b_hs) w_state_next = RSP;
      RD_ADDR: if (w_ar_hs) w_state_next = RD_DATA;
      RD_DATA: if (w_r_hs) w_state_next = RSP;
      RSP:     if (w_rsp_hs) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Next values of every registered output; each valid holds until its handshake.
  always_comb begin
    w_awvalid_next   = r_awvalid;
    w_wvalid_next    = r_wvalid;
    w_aw_done_next   = r_aw_done;
    w_w_done_next    = r_w_done;
    w_bready_next    = r_bready;
    w_arvalid_next   = r_arvalid;
    w_rready_next    = r_rready;
    w_rsp_valid_next = r_rsp_valid;
    w_rsp_we_next    = r_rsp_we;
    w_rsp_resp_next  = r_rsp_resp;
    w_rsp_rdata_next = r_rsp_rdata;
    w_wdata_next     = r_wdata;
    w_addr_next      = r_addr;
    unique case (r_state)
      IDLE: begin
        if (w_req_hs) begin
          w_addr_next    = bus.i_w_req_addr;
          w_wdata_next   = bus.i_w_req_wdata;
          w_awvalid_next = bus.i_w_req_we;
          w_wvalid_next  = bus.i_w_req_we;
          w_arvalid_next = !bus.i_w_req_we;
          w_aw_done_next = 1'b0;
          w_w_done_next  = 1'b0;
        end
      end
      WR: begin
        if (w_aw_hs) begin
          w_awvalid_next = 1'b0;
          w_aw_done_next = 1'b1;
        end
        if (w_w_hs) begin
          w_wvalid_next = 1'b0;
          w_w_done_next = 1'b1;
        end
        if (w_wr_done) w_bready_next = 1'b1;
      end
      WR_RESP: begin
        if (w_b_hs) begin
          w_bready_next    = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_we_next    = 1'b1;
          w_rsp_resp_next  = bus.i_w_bresp;
          w_rsp_rdata_next = '0;
        end
      end
      RD_ADDR: begin
        if (w_ar_hs) begin
          w_arvalid_next = 1'b0;
          w_rready_next  = 1'b1;
        end
      end
      RD_DATA: begin
        if (w_r_hs) begin
          w_rready_next    = 1'b0;
          w_rsp_valid_next = 1'b1;
          w_rsp_we_next    = 1'b0;
          w_rsp_resp_next  = bus.i_w_rresp;
          w_rsp_rdata_next = bus.i_w_rdata;
        end
      end
      RSP: begin
        if (w_rsp_hs) w_rsp_valid_next = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.o_w_req_ready = (r_state == IDLE);
  assign bus.o_w_rsp_valid = r_rsp_valid;
  assign bus.o_w_rsp_we    = r_rsp_we;
  assign bus.o_w_rsp_resp  = r_rsp_resp;
  assign bus.o_w_rsp_rdata = r_rsp_rdata;
  assign bus.o_w_awvalid   = r_awvalid;
  assign bus.o_w_awaddr    = r_addr;
  assign bus.o_w_wvalid    = r_wvalid;
  assign bus.o_w_wdata     = r_wdata;
  assign bus.o_w_bready    = r_bready;
  assign bus.o_w_arvalid   = r_arvalid;
  assign bus.o_w_araddr    = r_addr;
  assign bus.o_w_rready    = r_rready;
endmodule

// File: tb/tb_mem2axi.sv
// Directed bench for mem2axi against a small behavioural AXI4-Lite memory slave.
module tb_mem2axi;
  import axi_lite_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  int         aw_delay = 1;
  logic       rhold = 1'b0;
  logic [1:0] tb_bresp = RESP_OKAY;
  logic [1:0] tb_rresp = RESP_OKAY;
  int         b_count = 0;

  always #5 clk = ~clk;

  mem2axi_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  mem2axi #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .i_w_aclk   (clk),
    .i_w_areset (rst),
    .bus        (bus)
  );

  // Slave: AW ready after aw_delay cycles of AWVALID, W/AR ready at once,
  // B one cycle after both AW and W have landed, R one cycle after AR.
  logic [31:0] mem [0:255];
  logic        s_aw_got, s_w_got;
  logic [31:0] s_awaddr, s_wdata;
  int          aw_cnt;
  logic        aw_fire, w_fire;

  assign bus.i_w_awready = bus.o_w_awvalid && (aw_cnt == aw_delay - 1);
  assign bus.i_w_wready  = bus.o_w_wvalid;
  assign bus.i_w_arready = bus.o_w_arvalid;
  assign aw_fire = bus.o_w_awvalid && bus.i_w_awready;
  assign w_fire  = bus.o_w_wvalid && bus.i_w_wready;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_aw_got <= 1'b0;
      s_w_got <= 1'b0;
      s_awaddr <= '0;
      s_wdata <= '0;
      aw_cnt <= 0;
      bus.i_w_bvalid <= 1'b0;
      bus.i_w_bresp <= 2'b00;
      bus.i_w_rvalid <= 1'b0;
      bus.i_w_rresp <= 2'b00;
      bus.i_w_rdata <= '0;
    end else begin
      if (aw_fire) begin
        aw_cnt <= 0;
        s_awaddr <= bus.o_w_awaddr;
        s_aw_got <= 1'b1;
      end else if (bus.o_w_awvalid) begin
        aw_cnt <= aw_cnt + 1;
      end
      if (w_fire) begin
        s_wdata <= bus.o_w_wdata;
        s_w_got <= 1'b1;
      end
      if (bus.i_w_bvalid && bus.o_w_bready) bus.i_w_bvalid <= 1'b0;
      if ((s_aw_got || aw_fire) && (s_w_got || w_fire)) begin
        mem[aw_fire ? bus.o_w_awaddr[9:2] : s_awaddr[9:2]] <= w_fire ? bus.o_w_wdata : s_wdata;
        bus.i_w_bvalid <= 1'b1;
        bus.i_w_bresp <= tb_bresp;
        s_aw_got <= 1'b0;
        s_w_got <= 1'b0;
      end
      if (bus.i_w_rvalid && bus.o_w_rready) bus.i_w_rvalid <= 1'b0;
      if (bus.o_w_arvalid && bus.i_w_arready && !rhold) begin
        bus.i_w_rvalid <= 1'b1;
        bus.i_w_rdata <= mem[bus.o_w_araddr[9:2]];
        bus.i_w_rresp <= tb_rresp;
      end
    end
  end

  always @(posedge clk) if (bus.i_w_bvalid && bus.o_w_bready) b_count <= b_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] data);
    bus.i_w_req_valid = 1'b1;
    bus.i_w_req_we    = we;
    bus.i_w_req_addr  = addr;
    bus.i_w_req_wdata = data;
    tick();
    bus.i_w_req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!bus.o_w_rsp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("rsp_seen", {63'd0, bus.o_w_rsp_valid}, 64'd1);
  endtask

  task automatic finish_rsp();
    bus.i_w_rsp_ready = 1'b1;
    tick();
    bus.i_w_rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, aw_hi, w_hi, b0;
    logic addr_ok;
    bus.i_w_req_valid = 1'b0;
    bus.i_w_req_we    = 1'b0;
    bus.i_w_req_addr  = '0;
    bus.i_w_req_wdata = '0;
    bus.i_w_rsp_ready = 1'b0;

    #2 rst = 1'b1;
    #1;
    chk("rst_valids", {59'd0, bus.o_w_awvalid, bus.o_w_wvalid, bus.o_w_arvalid, bus.o_w_bready, bus.o_w_rready}, 64'd0);
    chk("rst_rsp", {61'd0, bus.o_w_rsp_valid, bus.o_w_rsp_resp}, 64'd0);
    @(posedge clk);
    tick();
    rst = 1'b0;
    tick();
    chk("rst_req_ready", {63'd0, bus.o_w_req_ready}, 64'd1);
    chk("rst_regs", {bus.o_w_awaddr, bus.o_w_rsp_rdata}, 64'd0);
    chk("rst_rsp_we", {63'd0, bus.o_w_rsp_we}, 64'd0);

    // Write, always-ready slave
    do_req(1'b1, 32'h10, 32'hDEADBEEF);
    chk("wr_aw_w_valid", {61'd0, bus.o_w_awvalid, bus.o_w_wvalid, bus.o_w_req_ready}, 64'd6);
    chk("wr_awaddr", {32'd0, bus.o_w_awaddr}, 64'h10);
    chk("wr_wdata", {32'd0, bus.o_w_wdata}, 64'hDEADBEEF);
    tick();
    chk("wr_b_phase", {61'd0, bus.o_w_awvalid, bus.o_w_wvalid, bus.o_w_bready}, 64'd1);
    chk("wr_rsp_not_yet", {63'd0, bus.o_w_rsp_valid}, 64'd0);
    tick();
    chk("wr_rsp_cycle3", {63'd0, bus.o_w_rsp_valid}, 64'd1);
    chk("wr_rsp_fields", {29'd0, bus.o_w_rsp_we, bus.o_w_rsp_resp, bus.o_w_rsp_rdata}, {29'd0, 1'b1, 2'b00, 32'h0});
    finish_rsp();
    chk("wr_rsp_done", {62'd0, bus.o_w_rsp_valid, bus.o_w_req_ready}, 64'd1);

    // Read back
    do_req(1'b0, 32'h10, 32'h0);
    chk("rd_arvalid", {63'd0, bus.o_w_arvalid}, 64'd1);
    chk("rd_araddr", {32'd0, bus.o_w_araddr}, 64'h10);
    wait_rsp(n);
    chk("rd_latency", n, 64'd2);
    chk("rd_rsp", {29'd0, bus.o_w_rsp_we, bus.o_w_rsp_resp, bus.o_w_rsp_rdata}, {29'd0, 1'b0, 2'b00, 32'hDEADBEEF});
    finish_rsp();

    // Skewed AW/W handshakes
    aw_delay = 5;
    b0 = b_count;
    aw_hi = 0;
    w_hi = 0;
    addr_ok = 1'b1;
    do_req(1'b1, 32'h40, 32'h12345678);
    n = 0;
    while (!bus.o_w_rsp_valid && n < 20) begin
      if (bus.o_w_awvalid) begin
        aw_hi++;
        if (bus.o_w_awaddr !== 32'h40) addr_ok = 1'b0;
      end
      if (bus.o_w_wvalid) w_hi++;
      tick();
      n++;
    end
    chk("skew_rsp_seen", {63'd0, bus.o_w_rsp_valid}, 64'd1);
    chk("skew_aw_cycles", aw_hi, 64'd5);
    chk("skew_w_cycles", w_hi, 64'd1);
    chk("skew_awaddr_stable", {63'd0, addr_ok}, 64'd1);
    chk("skew_b_count", b_count - b0, 64'd1);
    chk("skew_rsp", {61'd0, bus.o_w_rsp_we, bus.o_w_rsp_resp}, 64'd4);
    finish_rsp();
    aw_delay = 1;
    do_req(1'b0, 32'h40, 32'h0);
    wait_rsp(n);
    chk("skew_readback", {32'd0, bus.o_w_rsp_rdata}, 64'h12345678);
    finish_rsp();

    // Error pass-through
    tb_bresp = RESP_SLVERR;
    do_req(1'b1, 32'h20, 32'hA5A5A5A5);
    wait_rsp(n);
    chk("slverr_rsp", {29'd0, bus.o_w_rsp_we, bus.o_w_rsp_resp, bus.o_w_rsp_rdata}, {29'd0, 1'b1, 2'b10, 32'h0});
    finish_rsp();
    tb_bresp = RESP_OKAY;
    tb_rresp = RESP_DECERR;
    do_req(1'b0, 32'h10, 32'h0);
    wait_rsp(n);
    chk("decerr_rsp", {29'd0, bus.o_w_rsp_we, bus.o_w_rsp_resp, bus.o_w_rsp_rdata}, {29'd0, 1'b0, 2'b11, 32'hDEADBEEF});
    finish_rsp();
    tb_rresp = RESP_OKAY;

    // Response backpressure with a pending next request
    do_req(1'b1, 32'h30, 32'h0BADF00D);
    wait_rsp(n);
    bus.i_w_req_valid = 1'b1;
    bus.i_w_req_we    = 1'b0;
    bus.i_w_req_addr  = 32'h30;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold", {27'd0, bus.o_w_rsp_valid, bus.o_w_req_ready, bus.o_w_rsp_we, bus.o_w_rsp_resp, bus.o_w_rsp_rdata},
          {27'd0, 1'b1, 1'b0, 1'b1, 2'b00, 32'h0});
    end
    bus.i_w_rsp_ready = 1'b1;
    tick();
    bus.i_w_rsp_ready = 1'b0;
    chk("bp_release", {61'd0, bus.o_w_rsp_valid, bus.o_w_req_ready, bus.o_w_arvalid}, 64'd2);
    tick();
    bus.i_w_req_valid = 1'b0;
    chk("bp_next_accept", {31'd0, bus.o_w_arvalid, bus.o_w_araddr}, {31'd0, 1'b1, 32'h30});
    wait_rsp(n);
    chk("bp_next_rdata", {32'd0, bus.o_w_rsp_rdata}, 64'h0BADF00D);
    finish_rsp();

    // Reset while waiting for R
    rhold = 1'b1;
    do_req(1'b0, 32'h40, 32'h0);
    tick();
    chk("mid_rd_rready", {62'd0, bus.o_w_arvalid, bus.o_w_rready}, 64'd1);
    tick();
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_clear", {60'd0, bus.o_w_arvalid, bus.o_w_rready, bus.o_w_rsp_valid, bus.o_w_req_ready}, 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    rhold = 1'b0;
    tick();
    chk("post_rst_ready", {63'd0, bus.o_w_req_ready}, 64'd1);
    do_req(1'b0, 32'h40, 32'h0);
    wait_rsp(n);
    chk("post_rst_read", {30'd0, bus.o_w_rsp_resp, bus.o_w_rsp_rdata}, {30'd0, 2'b00, 32'h12345678});
    finish_rsp();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem2axi.md
Name: mem2axi

Overview:
AXI4-Lite initiator. Converts a simple single-beat memory request port (valid/ready, we, addr, wdata) into AXI4-Lite write (AW/W/B) or read (AR/R) transactions. It is the master-side counterpart of the team's AXI-to-memory slave, so the two can be connected back-to-back for loopback testing. At most one transaction is outstanding; the response is returned on a valid/ready response port.

Parameters:
ADDR_WIDTH, 32, width of request address and AXI AWADDR/ARADDR
DATA_WIDTH, 32, width of write/read data; must be 32 or 64

Ports:
i_w_aclk  input  1  clock; all logic on rising edge
i_w_areset  input  1  asynchronous reset, active-high
i_w_req_valid  input  1  request valid
o_w_req_ready  output  1  request accepted when valid&ready
i_w_req_we  input  1  1 = write, 0 = read
i_w_req_addr  input  ADDR_WIDTH  byte address
i_w_req_wdata  input  DATA_WIDTH  write data
o_w_rsp_valid  output  1  response valid
i_w_rsp_ready  input  1  response consumed when valid&ready
o_w_rsp_we  output  1  echo of request type
o_w_rsp_resp  output  2  BRESP or RRESP
o_w_rsp_rdata  output  DATA_WIDTH  read data; 0 for writes
o_w_awvalid  output  1  AW valid
i_w_awready  input  1  AW ready
o_w_awaddr  output  ADDR_WIDTH  write address
o_w_wvalid  output  1  W valid
i_w_wready  input  1  W ready
o_w_wdata  output  DATA_WIDTH  write data
o_w_bvalid-side: i_w_bvalid  input  1  B valid
o_w_bready  output  1  B ready
i_w_bresp  input  2  write response
o_w_arvalid  output  1  AR valid
i_w_arready  input  1  AR ready
o_w_araddr  output  ADDR_WIDTH  read address
i_w_rvalid  input  1  R valid
o_w_rready  output  1  R ready
i_w_rresp  input  2  read response
i_w_rdata  input  DATA_WIDTH  read data

Behaviour:
- Reset (async assert, sync release): state IDLE; all AXI valids/readies, o_w_rsp_valid, o_w_rsp_we and o_w_rsp_resp are 0; rdata/addr/wdata registers are 0. o_w_req_ready = (state==IDLE) and is therefore 1 after reset release.
- All AXI outputs are driven from registers (no combinational path from AXI inputs to AXI outputs).
- FSM states: IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: on req_valid&req_ready, latch addr/wdata/we. If we=1: next state WR, with awvalid=1 and wvalid=1 on the next cycle. If we=0: next state RD_ADDR, with arvalid=1.
- WR: AW and W are independent. awvalid drops the cycle after awvalid&awready; wvalid drops the cycle after wvalid&wready. Track aw_done/w_done. When both are done (including the case where both handshake in the same cycle), go to WR_RESP with bready=1.
- Valid stability: once asserted, a valid holds, and addr/data are held stable, until its handshake completes (AXI rule).
- WR_RESP: on bvalid&bready, capture bresp, drop bready, set rsp_we=1 and rsp_rdata=0, go to RSP.
- RD_ADDR: on arvalid&arready, drop arvalid, raise rready, go to RD_DATA.
- RD_DATA: on rvalid&rready, capture rdata/rresp, drop rready, set rsp_we=0, go to RSP.
- RSP: rsp_valid=1, with response fields held stable; on rsp_ready go to IDLE with rsp_valid=0.
- Minimum latency with an always-ready slave:
  - write: request accept to rsp_valid = 3 cycles (AW/W, B, RSP).
  - read: 3 cycles (AR, R, RSP).
  - back-to-back requests are accepted 1 cycle after the response handshake.
- SLVERR/DECERR are passed through unmodified; there is no retry.
- Reset mid-transaction clears all valids immediately; any in-flight transaction is dropped.

Decomposition:
- Shared package axi_lite_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11, and the FSM state encoding constants.
- No sub-module: the block is a single FSM with its channel registers.

Test Plan:
- Write, always-ready slave: req we=1 addr=0x10 wdata=0xDEADBEEF -> one AW beat (awaddr=0x10) and one W beat (wdata=0xDEADBEEF) in the same cycle; rsp_valid 3 cycles after accept; rsp_resp=0, rsp_we=1.
- Read back through the loopback axi2mem slave: req we=0 addr=0x10 -> araddr=0x10, rsp_rdata=0xDEADBEEF, rsp_resp=0.
- Skewed handshakes: awready delayed 5 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid is held 5 cycles, exactly one B accepted, response correct.
- Error pass-through: slave returns bresp=2'b10 on write and rresp=2'b11 on read -> rsp_resp=2 and 3 respectively.
- Response backpressure: rsp_ready held low 4 cycles -> rsp_valid and fields stable, req_ready=0 throughout; next request accepted 1 cycle after the rsp handshake.
- Reset mid-read: assert i_w_areset while in RD_DATA -> arvalid/rready/rsp_valid all 0 immediately; after release, req_ready=1 and a new read completes normally.
